io_selftest_sequencer: RTL and testbench

//  Synthesizable on-board successor to the sc_computer_with_io bench stimulus: drives the CPU's

---
 rtl/io_selftest_sequencer_pkg.sv | 29 ++
 rtl/io_selftest_sequencer_if.sv | 36 +++
 rtl/io_selftest_sequencer_compare.sv | 21 ++
 rtl/io_selftest_sequencer.sv | 163 ++++++++++++++++
 tb/tb_io_selftest_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_selftest_sequencer_pkg.sv
// Shared types and lane helpers for the I/O self-test sequencer.
// No ports: imported by the compare sub-module and the top.
package io_selftest_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST,
      FETCH,
      LOAD,
      SETTLE,
      CHECK,
      DONE
   } state_e;

   // Address width of an n-entry table, never below 1.
   function automatic int aw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Low bit of lane k in a bus of dw-wide lanes.
   function automatic int lane_lo(input int k, input int dw);
      return k * dw;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/io_selftest_sequencer_if.sv
// Vector-table read bus and computer-under-test port bundle.
// master = sequencer (drives addr/dut_resetn/in_port), slave = table + computer.
interface io_selftest_sequencer_if #(
   parameter int DW    = 32,
   parameter int N_IN  = 2,
   parameter int N_OUT = 2,
   parameter int AW    = 4
);
   logic [AW-1:0]       vec_addr;
   logic [N_IN*DW-1:0]  vec_in_data;
   logic [N_OUT*DW-1:0] vec_exp_data;
   logic [N_OUT*DW-1:0] vec_mask;
   logic                dut_resetn;
   logic [N_IN*DW-1:0]  in_port;
   logic [N_OUT*DW-1:0] out_port;

   modport master (
      output vec_addr,
      output dut_resetn,
      output in_port,
      input  vec_in_data,
      input  vec_exp_data,
      input  vec_mask,
      input  out_port
   );

   modport slave (
      input  vec_addr,
      input  dut_resetn,
      input  in_port,
      output vec_in_data,
      output vec_exp_data,
      output vec_mask,
      output out_port
   );
endinterface

// File: rtl/io_selftest_sequencer_compare.sv
// Per-lane masked compare of computer outputs against expected values.
// out_i/exp_i/mask_i: N_OUT lanes of DW bits; mis_o[k]=1 when lane k differs.
module io_port_compare
   import io_selftest_pkg::*;
#(
   parameter int DW    = 32,
   parameter int N_OUT = 2
) (
   input  logic [N_OUT*DW-1:0] out_i,
   input  logic [N_OUT*DW-1:0] exp_i,
   input  logic [N_OUT*DW-1:0] mask_i,
   output logic [N_OUT-1:0]    mis_o
);

   for (genvar k = 0; k < N_OUT; k++) begin : g_lane
      localparam int LO = lane_lo(k, DW);
      assign mis_o[k] = |((out_i[LO +: DW] ^ exp_i[LO +: DW])
                          & mask_i[LO +: DW]);
   end

endmodule

// File: rtl/io_selftest_sequencer.sv
// On-board self-test sequencer: resets the computer, applies table vectors,
// waits a settle time and checks masked outputs.
// Ports: clock/resetn, start/abort control, bus (table + computer ports),
// busy/done/pass status, err_count, first_fail, fail_ports results.
module io_selftest_sequencer
   import io_selftest_pkg::*;
#(
   parameter  int DW            = 32,
   parameter  int N_IN          = 2,
   parameter  int N_OUT         = 2,
   parameter  int N_VEC         = 16,
   parameter  int RESET_CYCLES  = 4,
   parameter  int SETTLE_CYCLES = 1000,
   localparam int AW            = aw_of(N_VEC)
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    start,
   input  logic                    abort,
   io_selftest_sequencer_if.master bus,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [AW:0]             err_count,
   output logic [AW-1:0]           first_fail,
   output logic [N_OUT-1:0]        fail_ports
);

   localparam int CW = $clog2(max2(RESET_CYCLES, SETTLE_CYCLES) + 1);

   localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [AW-1:0] VEC_LAST = AW'(N_VEC - 1);

   state_e              state_q;
   logic [CW-1:0]       cnt_q;
   logic [AW-1:0]       addr_q;
   logic [N_IN*DW-1:0]  in_q;
   logic [N_OUT*DW-1:0] exp_q;
   logic [N_OUT*DW-1:0] mask_q;
   logic                dutrst_q;
   logic                busy_q;
   logic                done_q;
   logic                pass_q;
   logic [AW:0]         err_q;
   logic [AW-1:0]       ff_q;
   logic [N_OUT-1:0]    fp_q;
   logic [N_OUT-1:0]    mis;
   logic                any_mis;

   io_port_compare #(
      .DW    (DW),
      .N_OUT (N_OUT)
   ) u_cmp (
      .out_i  (bus.out_port),
      .exp_i  (exp_q),
      .mask_i (mask_q),
      .mis_o  (mis)
   );

   assign any_mis = |mis;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         in_q     <= '0;
         exp_q    <= '0;
         mask_q   <= '0;
         dutrst_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         ff_q     <= '0;
         fp_q     <= '0;
      end else if (abort) begin
         // Results stay visible after an abort; only the run is dropped.
         state_q  <= IDLE;
         dutrst_q <= 1'b0;
         in_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q  <= RST;
                  cnt_q    <= '0;
                  addr_q   <= '0;
                  in_q     <= '0;
                  dutrst_q <= 1'b0;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
                  pass_q   <= 1'b0;
                  err_q    <= '0;
                  ff_q     <= '0;
                  fp_q     <= '0;
               end
            end
            RST: begin
               if (cnt_q == RST_LAST) begin
                  state_q <= FETCH;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            FETCH: begin
               state_q  <= LOAD;
               dutrst_q <= 1'b1;
            end
            LOAD: begin
               // Table data for addr_q is valid now (1-cycle read).
               in_q    <= bus.vec_in_data;
               exp_q   <= bus.vec_exp_data;
               mask_q  <= bus.vec_mask;
               cnt_q   <= '0;
               state_q <= SETTLE;
            end
            SETTLE: begin
               if (cnt_q == SET_LAST) begin
                  state_q <= CHECK;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            CHECK: begin
               if (any_mis) begin
                  err_q <= err_q + (AW+1)'(1);
                  if (err_q == '0) begin
                     ff_q <= addr_q;
                     fp_q <= mis;
                  end
               end
               if (addr_q == VEC_LAST) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_q == '0) && !any_mis;
               end else begin
                  addr_q  <= addr_q + AW'(1);
                  state_q <= FETCH;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.vec_addr   = addr_q;
   assign bus.dut_resetn = dutrst_q;
   assign bus.in_port    = in_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_fail     = ff_q;
   assign fail_ports     = fp_q;

endmodule

// File: tb/tb_io_selftest_sequencer.sv
// Bench for io_selftest_sequencer: 1-cycle-latency table model, loopback
// computer (out_port = in_port), run-result scoreboard.
module tb_io_selftest_sequencer;

   localparam int DW    = 32;
   localparam int NI    = 2;
   localparam int NO    = 2;
   localparam int NV    = 4;
   localparam int RC    = 4;
   localparam int SC    = 8;
   localparam int AW    = 2;
   localparam int RUN_C = RC + NV * (SC + 3);

   typedef struct {
      string           name;
      logic [AW:0]     err;
      logic [AW-1:0]   ff;
      logic [NO-1:0]   fp;
      logic            pass;
      int              cycles;
   } exp_t;

   logic          clk;
   logic          resetn;
   logic          start;
   logic          abort;
   logic          busy;
   logic          done;
   logic          pass;
   logic [AW:0]   err_count;
   logic [AW-1:0] first_fail;
   logic [NO-1:0] fail_ports;

   logic [NI*DW-1:0] tin   [NV];
   logic [NO*DW-1:0] texp  [NV];
   logic [NO*DW-1:0] tmask [NV];

   exp_t sb[$];
   int   total;
   int   bad;

   io_selftest_sequencer_if #(
      .DW(DW), .N_IN(NI), .N_OUT(NO), .AW(AW)
   ) bus ();

   io_selftest_sequencer #(
      .DW(DW), .N_IN(NI), .N_OUT(NO), .N_VEC(NV),
      .RESET_CYCLES(RC), .SETTLE_CYCLES(SC)
   ) dut (
      .clock      (clk),
      .resetn     (resetn),
      .start      (start),
      .abort      (abort),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .first_fail (first_fail),
      .fail_ports (fail_ports)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) begin
      bus.vec_in_data  <= tin[bus.vec_addr];
      bus.vec_exp_data <= texp[bus.vec_addr];
      bus.vec_mask     <= tmask[bus.vec_addr];
   end

   assign bus.out_port = bus.in_port;

   task automatic set_clean();
      for (int v = 0; v < NV; v++) begin
         tin[v][31:0]  = 32'h1234_0000 + 32'(v);
         tin[v][63:32] = 32'hCAFE_0000 + 32'(v * 2);
         texp[v]       = tin[v];
         tmask[v]      = '1;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called right after pulse_start; cycles counted from the start edge.
   task automatic sb_compare_run(input int inject);
      exp_t        e;
      int          cyc;
      int          rst_low;
      int          nchg;
      logic        seen_hi;
      logic        seq_ok;
      logic [AW-1:0] prev;
      logic [AW-1:0] nxt;
      cyc     = 0;
      nchg    = 0;
      seq_ok  = 1'b1;
      seen_hi = bus.dut_resetn;
      rst_low = bus.dut_resetn ? 0 : 1;
      prev    = bus.vec_addr;
      nxt     = prev + AW'(1);
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = (cyc == inject);
         if (!seen_hi) begin
            if (bus.dut_resetn) seen_hi = 1'b1;
            else rst_low++;
         end
         if (bus.vec_addr != prev) begin
            if (bus.vec_addr != nxt) seq_ok = 1'b0;
            nchg++;
            prev = bus.vec_addr;
            nxt  = prev + AW'(1);
         end
      end
      start = 1'b0;
      e = sb.pop_front();
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL %s done_timeout: got %b want 1", e.name, done);
      end
      total++;
      if (cyc !== e.cycles) begin
         bad++;
         $display("FAIL %s cycles: got %0d want %0d", e.name, cyc, e.cycles);
      end
      total++;
      if (err_count !== e.err) begin
         bad++;
         $display("FAIL %s err_count: got %0d want %0d",
                  e.name, err_count, e.err);
      end
      total++;
      if (first_fail !== e.ff) begin
         bad++;
         $display("FAIL %s first_fail: got %0d want %0d",
                  e.name, first_fail, e.ff);
      end
      total++;
      if (fail_ports !== e.fp) begin
         bad++;
         $display("FAIL %s fail_ports: got %b want %b",
                  e.name, fail_ports, e.fp);
      end
      total++;
      if (pass !== e.pass) begin
         bad++;
         $display("FAIL %s pass: got %b want %b", e.name, pass, e.pass);
      end
      total++;
      if (busy !== 1'b0 || bus.dut_resetn !== 1'b1) begin
         bad++;
         $display("FAIL %s done_state: busy=%b dut_resetn=%b want 0/1",
                  e.name, busy, bus.dut_resetn);
      end
      total++;
      if (bus.in_port !== tin[NV-1]) begin
         bad++;
         $display("FAIL %s in_port_hold: got %h want %h",
                  e.name, bus.in_port, tin[NV-1]);
      end
      total++;
      if (!seq_ok || nchg != NV - 1) begin
         bad++;
         $display("FAIL %s addr_seq: ok=%b changes=%0d want 1/%0d",
                  e.name, seq_ok, nchg, NV - 1);
      end
      total++;
      if (rst_low < RC || rst_low > RC + 2) begin
         bad++;
         $display("FAIL %s dut_reset_len: got %0d want %0d..%0d",
                  e.name, rst_low, RC, RC + 2);
      end
   endtask

   task automatic test_reset();
      total++;
      if ({busy, done, pass, bus.dut_resetn} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags: got %b want 0000",
                  {busy, done, pass, bus.dut_resetn});
      end
      total++;
      if ({err_count, first_fail, fail_ports} !== '0) begin
         bad++;
         $display("FAIL reset_results: got %h want 0",
                  {err_count, first_fail, fail_ports});
      end
      total++;
      if (bus.in_port !== '0 || bus.vec_addr !== '0) begin
         bad++;
         $display("FAIL reset_ports: in=%h addr=%0d want 0/0",
                  bus.in_port, bus.vec_addr);
      end
   endtask

   task automatic test_clean_run();
      set_clean();
      sb.push_back('{"clean", 3'd0, 2'd0, 2'b00, 1'b1, RUN_C});
      pulse_start();
      total++;
      if (busy !== 1'b1 || bus.dut_resetn !== 1'b0) begin
         bad++;
         $display("FAIL clean_busy: busy=%b dut_resetn=%b want 1/0",
                  busy, bus.dut_resetn);
      end
      sb_compare_run(0);
   endtask

   task automatic test_single_mismatch();
      set_clean();
      tin[2][63:32]  = 32'h0000_00FE;
      texp[2][63:32] = 32'h0000_00FF;
      sb.push_back('{"single", 3'd1, 2'd2, 2'b10, 1'b0, RUN_C});
      pulse_start();
      sb_compare_run(0);
   endtask

   task automatic test_masked();
      set_clean();
      tin[2][63:32]   = 32'h0000_00FE;
      texp[2][63:32]  = 32'h0000_00FF;
      tmask[2][63:32] = 32'hFFFF_FF00;
      sb.push_back('{"masked", 3'd0, 2'd0, 2'b00, 1'b1, RUN_C});
      pulse_start();
      sb_compare_run(0);
   endtask

   task automatic test_two_mismatch();
      set_clean();
      texp[1][31:0]  = texp[1][31:0] ^ 32'h0000_0001;
      texp[3][63:32] = texp[3][63:32] ^ 32'h8000_0000;
      sb.push_back('{"two", 3'd2, 2'd1, 2'b01, 1'b0, RUN_C});
      pulse_start();
      sb_compare_run(0);
   endtask

   task automatic test_abort();
      set_clean();
      texp[0][31:0] = texp[0][31:0] ^ 32'h0000_0010;
      pulse_start();
      // After 19 edges the run sits in SETTLE of vector 1.
      repeat (19) @(negedge clk);
      total++;
      if (bus.vec_addr !== 2'd1 || bus.in_port !== tin[1]) begin
         bad++;
         $display("FAIL abort_pre: addr=%0d in=%h want 1/%h",
                  bus.vec_addr, bus.in_port, tin[1]);
      end
      total++;
      if (err_count !== 3'd1) begin
         bad++;
         $display("FAIL abort_pre_err: got %0d want 1", err_count);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++;
      if ({busy, done, bus.dut_resetn} !== 3'b000 || bus.in_port !== '0) begin
         bad++;
         $display("FAIL abort_idle: bdr=%b in=%h want 000/0",
                  {busy, done, bus.dut_resetn}, bus.in_port);
      end
      total++;
      if (err_count !== 3'd1 || first_fail !== 2'd0) begin
         bad++;
         $display("FAIL abort_keep: err=%0d ff=%0d want 1/0",
                  err_count, first_fail);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || bus.vec_addr !== 2'd1) begin
         bad++;
         $display("FAIL abort_stay: busy=%b addr=%0d want 0/1",
                  busy, bus.vec_addr);
      end
      set_clean();
      sb.push_back('{"restart", 3'd0, 2'd0, 2'b00, 1'b1, RUN_C});
      pulse_start();
      total++;
      if (err_count !== 3'd0 || bus.vec_addr !== 2'd0) begin
         bad++;
         $display("FAIL restart_clear: err=%0d addr=%0d want 0/0",
                  err_count, bus.vec_addr);
      end
      sb_compare_run(0);
   endtask

   task automatic test_async_reset();
      set_clean();
      texp[0][63:32] = ~texp[0][63:32];
      pulse_start();
      repeat (20) @(negedge clk);
      resetn = 1'b0;
      #1;
      total++;
      if ({busy, done, pass, bus.dut_resetn} !== 4'b0000) begin
         bad++;
         $display("FAIL async_flags: got %b want 0000",
                  {busy, done, pass, bus.dut_resetn});
      end
      total++;
      if ({err_count, first_fail, fail_ports} !== '0) begin
         bad++;
         $display("FAIL async_results: got %h want 0",
                  {err_count, first_fail, fail_ports});
      end
      total++;
      if (bus.in_port !== '0 || bus.vec_addr !== '0) begin
         bad++;
         $display("FAIL async_ports: in=%h addr=%0d want 0/0",
                  bus.in_port, bus.vec_addr);
      end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_start_while_busy();
      set_clean();
      texp[2][31:0] = texp[2][31:0] ^ 32'h0100_0000;
      sb.push_back('{"busy_start", 3'd1, 2'd2, 2'b01, 1'b0, RUN_C});
      pulse_start();
      sb_compare_run(17);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      resetn = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      set_clean();
      repeat (3) @(negedge clk);
      test_reset();
      resetn = 1'b1;
      @(negedge clk);
      test_reset();
      test_clean_run();
      test_single_mismatch();
      test_masked();
      test_two_mismatch();
      test_abort();
      test_async_reset();
      test_start_while_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
